// File: rtl/param_mem_ctrl.sv
// param_mem_ctrl: single-port word memory with valid/ready request/response channels and byte enables.
// Define PARAM_MEM_CLR_EN to zero the whole array after every reset release.
`timescale 1ns/1ps
module param_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int BE_W = DATA_W / 8;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;
`ifdef PARAM_MEM_CLR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_cnt;
`else
    localparam state_t RST_STATE = IDLE;
`endif
    state_t              state, state_nxt;
    logic                rdy_en, wr_q, in_range;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, wr_word;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    // one extra bit so DEPTH == 2**ADDR_W never flags an error
    assign in_range = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rdy_en;
                if (req_valid && rdy_en) state_nxt = ACCESS;
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
`ifdef PARAM_MEM_CLR_EN
            default: state_nxt = (clr_cnt == ADDR_W'(DEPTH - 1)) ? IDLE : CLEAR;
`else
            default: state_nxt = IDLE;
`endif
        endcase
    end
    always_comb begin
        wr_word = mem[addr_q];
        for (int i = 0; i < BE_W; i++)
            if (be_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            rdy_en    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef PARAM_MEM_CLR_EN
            clr_cnt   <= '0;
`endif
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (req_valid && req_ready) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state == ACCESS) begin
                rsp_err   <= !in_range;
                rsp_rdata <= (in_range && !wr_q) ? mem[addr_q] : '0;
            end
            if (state == RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
`ifdef PARAM_MEM_CLR_EN
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
`endif
        end
    end
    // storage has no reset; the FSM alone decides when a word is written
    always_ff @(posedge clk) begin
`ifdef PARAM_MEM_CLR_EN
        if (state == CLEAR) mem[clr_cnt] <= '0;
`endif
        if (state == ACCESS && wr_q && in_range) mem[addr_q] <= wr_word;
    end
endmodule

// File: tb/tb_param_mem_ctrl.sv
// tb_param_mem_ctrl: scoreboard bench for param_mem_ctrl with directed and random traffic.
`timescale 1ns/1ps
module tb_param_mem_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
`ifdef PARAM_MEM_CLR_EN
    localparam int REL_EDGES = DEPTH;
`else
    localparam int REL_EDGES = 1;
`endif
    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    int          vectors = 0, errors = 0;
    bit          rr_rand = 1'b1, rr_val = 1'b1;

    param_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    initial forever begin
        @(negedge clk);
        rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end

    // monitor: every presented response is compared against the queue head
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) flag("rsp_unexpected");
                else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].d);
                    chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].e));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_rdata", rsp_rdata, 32'h0);
                chk("idle_err", 32'(rsp_err), 32'h0);
            end
        end
    end

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
`ifdef PARAM_MEM_CLR_EN
            ref_mem[a] = '0;
            known[a]   = 1'b1;
`endif
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) flag("req_ready_timeout");
    endtask

    task automatic send(input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
        rsp_t r;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = 8'(a);
        req_wdata = d;
        req_be    = be;
        r.d = '0;
        r.e = (a >= DEPTH);
        if (!r.e) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
                if (be == 4'hF) known[a] = 1'b1;
            end else r.d = ref_mem[a];
        end
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        chk("lat_access_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_resp_valid", 32'(rsp_valid), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (exp_q.size() != 0) begin
            flag("drain_timeout");
            exp_q.delete();
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 32'(req_ready), 32'h0);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (REL_EDGES - 1) @(posedge clk);
        #1;
        chk("rel_ready_still_low", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", 32'(req_ready), 32'h1);
        model_reset();
    endtask

    initial begin
        int a, op;
        logic [31:0] d;
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        release_reset();

        send(1'b1, 1, 32'h55AA33CC, 4'hF);
        send(1'b0, 1, 32'h0, 4'h0);
        send(1'b1, 1, 32'h11223344, 4'b0101);
        send(1'b0, 1, 32'h0, 4'h0);
        send(1'b0, 200, 32'h0, 4'h0);
        send(1'b1, 255, 32'hCAFEF00D, 4'hF);
        send(1'b1, 1, 32'hFFFFFFFF, 4'h0);
        send(1'b0, 1, 32'h0, 4'h0);
        drain();

        rr_rand = 1'b0;
        rr_val  = 1'b0;
        send(1'b0, 1, 32'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 8'd1;
            req_wdata = 32'hFFFFFFFF;
            req_be    = 4'hF;
        end
        req_valid = 1'b0;
        rr_val    = 1'b1;
        drain();
        @(posedge clk);
        #1;
        chk("post_stall_ready", 32'(req_ready), 32'h1);
        rr_rand = 1'b1;
        send(1'b0, 1, 32'h0, 4'h0);

        for (int k = 0; k < 150; k++) begin
            a  = $urandom_range(0, 255);
            op = $urandom_range(0, 2);
            d  = $urandom;
            if (a < DEPTH && !known[a]) send(1'b1, a, d, 4'hF);
            else if (op == 0) send(1'b0, a, 32'h0, 4'h0);
            else if (op == 1) send(1'b1, a, d, 4'($urandom));
            else send(1'b1, a, d, 4'hF);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // reset while a write sits in ACCESS: the write must be dropped
        send(1'b1, 2, 32'h00000007, 4'hF);
        drain();
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 8'd2;
            req_wdata = 32'hDEADBEEF;
            req_be    = 4'hF;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rst_n     = 1'b0;
            #1;
            chk("midwr_req_ready", 32'(req_ready), 32'h0);
            chk("midwr_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("midwr_rsp_rdata", rsp_rdata, 32'h0);
            chk("midwr_rsp_err", 32'(rsp_err), 32'h0);
        end
        repeat (2) @(negedge clk);
        release_reset();
        send(1'b0, 2, 32'h0, 4'h0);
        drain();

        // reset while an out-of-range response is stalled: it vanishes at once
        rr_rand = 1'b0;
        rr_val  = 1'b0;
        send(1'b0, 250, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrsp_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrsp_rsp_err", 32'(rsp_err), 32'h0);
        chk("midrsp_req_ready", 32'(req_ready), 32'h0);
        rr_rand = 1'b1;
        repeat (2) @(negedge clk);
        release_reset();
        send(1'b0, 2, 32'h0, 4'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
